// File: rtl/comparator_multich_debounce_if.sv
// comparator_multich_debounce_if
// Groups the stream handshake, operand buses, result/alarm outputs and the
// soft-clear/alarm-clear controls of comparator_multich_debounce.
//   clr        soft clear (master -> slave)
//   in_valid   sample beat valid (master -> slave)
//   in_ready   slave can accept a beat (slave -> master)
//   A, B       packed per-channel operands/thresholds, channel k at [k*WIDTH +: WIDTH]
//   out_valid  comp_out holds an unconsumed result (slave -> master)
//   out_ready  downstream accepts the result (master -> slave)
//   comp_out   per-channel one-hot state, 3 bits per channel (slave -> master)
//   alarm      sticky per-channel GT alarm (slave -> master)
//   alarm_clr  per-channel alarm clear (master -> slave)
interface comparator_multich_debounce_if #(
  parameter int WIDTH = 14,
  parameter int NCH   = 4
);
  logic                   clr;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH*NCH-1:0]   A;
  logic [WIDTH*NCH-1:0]   B;
  logic                   out_valid;
  logic                   out_ready;
  logic [3*NCH-1:0]       comp_out;
  logic [NCH-1:0]         alarm;
  logic [NCH-1:0]         alarm_clr;

  modport master (
    output clr, in_valid, A, B, out_ready, alarm_clr,
    input  in_ready, out_valid, comp_out, alarm
  );

  modport slave (
    input  clr, in_valid, A, B, out_ready, alarm_clr,
    output in_ready, out_valid, comp_out, alarm
  );
endinterface

// File: rtl/comparator_multich_debounce.sv
// comparator_multich_debounce
// NCH independent A-vs-B magnitude comparators with an equality half-window
// (HYST), signed/unsigned operands, per-channel persistence filtering, a
// sticky over-threshold alarm and valid/ready streaming on input and output.
// Ports:
//   iclk   clock, rising edge
//   irst   asynchronous active-high reset
//   bus    comparator_multich_debounce_if.slave (handshake, operands,
//          comp_out, alarm, clr, alarm_clr)
// comp_out encoding per channel: 001=LT, 010=EQ, 100=GT, 000=NONE.
module comparator_multich_debounce #(
  parameter int WIDTH   = 14,
  parameter int NCH     = 4,
  parameter int SIGNED  = 0,
  parameter int HYST    = 0,
  parameter int PERSIST = 3
) (
  input  logic                           iclk,
  input  logic                           irst,
  comparator_multich_debounce_if.slave   bus
);

  localparam int CW = $clog2(PERSIST + 1);

  localparam logic signed [WIDTH:0] HLIM  = (WIDTH+1)'(HYST);
  localparam logic signed [WIDTH:0] NHLIM = -HLIM;
  localparam logic [CW:0]           PCMP  = (CW+1)'(PERSIST);

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_LT   = 2'd1,
    ST_EQ   = 2'd2,
    ST_GT   = 2'd3
  } state_t;

  state_t                  state_q [NCH];
  state_t                  cand_q  [NCH];
  logic [CW-1:0]           cnt_q   [NCH];
  state_t                  state_d [NCH];
  state_t                  cand_d  [NCH];
  logic [CW-1:0]           cnt_d   [NCH];
  state_t                  raw     [NCH];
  logic signed [WIDTH:0]   diff    [NCH];
  logic [NCH-1:0]          enter_gt;
  logic [3*NCH-1:0]        comp_d;

  logic [3*NCH-1:0]        comp_q;
  logic [NCH-1:0]          alarm_q;
  logic                    out_valid_q;
  logic                    in_ready;
  logic                    accept;

  // One extra bit keeps A-B exact for both signed and unsigned operands.
  function automatic logic signed [WIDTH:0] ext(input logic [WIDTH-1:0] v);
    if (SIGNED != 0) ext = {v[WIDTH-1], v};
    else             ext = {1'b0, v};
  endfunction

  function automatic logic [2:0] onehot(input state_t s);
    case (s)
      ST_LT:   onehot = 3'b001;
      ST_EQ:   onehot = 3'b010;
      ST_GT:   onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.clr;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.comp_out  = comp_q;
  assign bus.alarm     = alarm_q;

  // Raw windowed classification of each channel.
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      diff[k] = ext(bus.A[k*WIDTH +: WIDTH]) - ext(bus.B[k*WIDTH +: WIDTH]);
      if (diff[k] > HLIM)       raw[k] = ST_GT;
      else if (diff[k] < NHLIM) raw[k] = ST_LT;
      else                      raw[k] = ST_EQ;
    end
  end

  // Persistence filter next-state; only committed on an accepted beat.
  always_comb begin
    enter_gt = '0;
    comp_d   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      cand_d[k]  = cand_q[k];
      cnt_d[k]   = cnt_q[k];
      if (state_q[k] == ST_NONE) begin
        state_d[k] = raw[k];
        cnt_d[k]   = '0;
      end else if (raw[k] == state_q[k]) begin
        cnt_d[k] = '0;
      end else if (raw[k] == cand_q[k]) begin
        if (({1'b0, cnt_q[k]} + 1'b1) == PCMP) begin
          state_d[k] = raw[k];
          cnt_d[k]   = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end else begin
        cand_d[k] = raw[k];
        if (PERSIST == 1) begin
          state_d[k] = raw[k];
          cnt_d[k]   = '0;
        end else begin
          cnt_d[k] = CW'(1);
        end
      end
      enter_gt[k]       = (state_d[k] == ST_GT) && (state_q[k] != ST_GT);
      comp_d[k*3 +: 3]  = onehot(state_d[k]);
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      out_valid_q <= 1'b0;
      comp_q      <= '0;
      alarm_q     <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        state_q[k] <= ST_NONE;
        cand_q[k]  <= ST_NONE;
        cnt_q[k]   <= '0;
      end
    end else begin
      // A set on the same edge as alarm_clr wins.
      alarm_q <= (alarm_q & ~bus.alarm_clr) | (accept ? enter_gt : '0);
      if (bus.clr) begin
        out_valid_q <= 1'b0;
        comp_q      <= '0;
        for (int unsigned k = 0; k < NCH; k++) begin
          state_q[k] <= ST_NONE;
          cand_q[k]  <= ST_NONE;
          cnt_q[k]   <= '0;
        end
      end else if (accept) begin
        out_valid_q <= 1'b1;
        comp_q      <= comp_d;
        for (int unsigned k = 0; k < NCH; k++) begin
          state_q[k] <= state_d[k];
          cand_q[k]  <= cand_d[k];
          cnt_q[k]   <= cnt_d[k];
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
